dpa_alu_driver: RTL and testbench

//  Initiator for the masked DPA ALU. Accepts plain operand/opcode requests (valid/ready) and splits operands

---
 rtl/dpa_alu_drv_pkg.sv | 51 +++++
 rtl/dpa_mask_lfsr.sv | 39 +++
 rtl/dpa_alu_driver.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dpa_alu_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpa_alu_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpa_alu_drv_pkg
// Purpose  : Shared state encodings, ALU field codes, control struct and
//            helpers for the masked DPA ALU driver.
// Revision : 1.0 - initial release
// ============================================================================
package dpa_alu_drv_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MASK  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [2:0] SHIFT_NONE = 3'b000;
    localparam logic [2:0] SHIFT_SRA1 = 3'b001;
    localparam logic [2:0] SHIFT_SLL1 = 3'b010;
    localparam logic [2:0] SHIFT_SRL1 = 3'b011;

    localparam logic [1:0] FUNC_ADD        = 2'b00;
    localparam logic [1:0] REG1_SEL_REG1   = 2'b00;
    localparam logic [1:0] REG1_SEL_CONST0 = 2'b10;

    typedef struct packed {
        logic       carry_in;
        logic [1:0] reg_1_sel;
        logic       invert_sel;
        logic [1:0] function_array_sel;
        logic [2:0] shift_sel;
    } alu_ctrl_t;

    // Right-shift Galois masks; the top bit is always set so the map is
    // invertible and a non-zero state can never reach zero.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

    // Random words per op: SHARES-1 for each operand plus r_1..r_3.
    function automatic int unsigned mask_words(input int unsigned shares);
        return 2 * (shares - 1) + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpa_mask_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : dpa_mask_lfsr
// Purpose  : Free-running Galois LFSR producing one mask word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dpa_mask_lfsr
    import dpa_alu_drv_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [WIDTH-1:0] word_o
);

    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= state_d;
        end
    end

    assign word_o = state_q;

endmodule
`default_nettype wire

// File: rtl/dpa_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : dpa_alu_driver
// Purpose  : Splits plain requests into Boolean shares, drives the masked ALU
//            handshake and returns the recombined result. Optional WAIT
//            timeout enabled by DPA_ALU_DRV_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dpa_alu_driver
    import dpa_alu_drv_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               SHARES         = 3,
    parameter logic [WIDTH-1:0] LFSR_SEED      = WIDTH'(32'hACE1_2468),
    parameter int               TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDTH-1:0]        req_op_a,
    input  logic [WIDTH-1:0]        req_op_b,
    input  logic [WIDTH-1:0]        req_const_w,
    input  logic                    req_carry_in,
    input  logic [1:0]              req_reg_1_sel,
    input  logic                    req_invert_sel,
    input  logic [1:0]              req_function_array_sel,
    input  logic [2:0]              req_shift_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_carry_out,
    output logic                    rsp_error,
    output logic [SHARES*WIDTH-1:0] alu_reg_1,
    output logic [SHARES*WIDTH-1:0] alu_reg_2,
    output logic [WIDTH-1:0]        alu_const_w,
    output logic [WIDTH-1:0]        alu_const_0,
    output logic                    alu_carry_in,
    output logic [1:0]              alu_reg_1_sel,
    output logic                    alu_invert_sel,
    output logic [1:0]              alu_function_array_sel,
    output logic [2:0]              alu_shift_sel,
    output logic [WIDTH-1:0]        alu_r_1,
    output logic [WIDTH-1:0]        alu_r_2,
    output logic [WIDTH-1:0]        alu_r_3,
    output logic                    alu_enable,
    input  logic [SHARES*WIDTH-1:0] alu_out,
    input  logic [SHARES-1:0]       alu_carry_out,
    input  logic                    alu_ready
);

    localparam int unsigned M  = mask_words(SHARES);
    localparam int          CW = $clog2(M);

    if (SHARES < 2) begin : g_bad_shares
        $error("dpa_alu_driver: SHARES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dpa_alu_driver: TIMEOUT_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] lfsr_word;

    dpa_mask_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .word_o  (lfsr_word)
    );

    logic [2:0]              state_q,     state_d;
    logic [CW-1:0]           cnt_q,       cnt_d;
    logic [WIDTH-1:0]        a_q,         a_d;
    logic [WIDTH-1:0]        b_q,         b_d;
    alu_ctrl_t               ctrl_q,      ctrl_d;
    logic [WIDTH-1:0]        const_w_q,   const_w_d;
    logic [SHARES*WIDTH-1:0] reg1_q,      reg1_d;
    logic [SHARES*WIDTH-1:0] reg2_q,      reg2_d;
    logic [WIDTH-1:0]        r1_q,        r1_d;
    logic [WIDTH-1:0]        r2_q,        r2_d;
    logic [WIDTH-1:0]        r3_q,        r3_d;
    logic                    enable_q,    enable_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]        result_q,    result_d;
    logic                    carry_q,     carry_d;
    logic [WIDTH-1:0]        res_x;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           wait_cnt_q,  wait_cnt_d;
    logic                    error_q,     error_d;
`endif

    always_comb begin
        res_x = '0;
        for (int i = 0; i < SHARES; i++) begin
            res_x = res_x ^ alu_out[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        const_w_d   = const_w_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        enable_d    = enable_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        error_d     = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d       = req_op_a;
                    b_d       = req_op_b;
                    const_w_d = req_const_w;
                    ctrl_d    = '{req_carry_in, req_reg_1_sel, req_invert_sel,
                                  req_function_array_sel, req_shift_sel};
                    reg1_d    = '0;
                    reg2_d    = '0;
                    cnt_d     = '0;
                    state_d   = ST_MASK;
                end
            end
            ST_MASK: begin
                // a_q/b_q fold in every random share so they end up as the last share.
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < SHARES - 1; i++) begin
                    if (cnt_q == CW'(i)) begin
                        reg1_d[i*WIDTH +: WIDTH] = lfsr_word;
                        a_d                      = a_q ^ lfsr_word;
                    end
                    if (cnt_q == CW'(SHARES - 1 + i)) begin
                        reg2_d[i*WIDTH +: WIDTH] = lfsr_word;
                        b_d                      = b_q ^ lfsr_word;
                    end
                end
                if (cnt_q == CW'(M - 3)) r1_d = lfsr_word;
                if (cnt_q == CW'(M - 2)) r2_d = lfsr_word;
                if (cnt_q == CW'(M - 1)) begin
                    r3_d                                = lfsr_word;
                    reg1_d[(SHARES-1)*WIDTH +: WIDTH]   = a_q;
                    reg2_d[(SHARES-1)*WIDTH +: WIDTH]   = b_q;
                    a_d                                 = '0;
                    b_d                                 = '0;
                    cnt_d                               = '0;
                    state_d                             = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                enable_d = 1'b1;
                state_d  = ST_WAIT;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (alu_ready) begin
                    result_d    = res_x;
                    carry_d     = ^alu_carry_out;
                    enable_d    = 1'b0;
                    r1_d        = '0;
                    r2_d        = '0;
                    r3_d        = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
                end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    result_d    = '0;
                    carry_d     = 1'b0;
                    error_d     = 1'b1;
                    enable_d    = 1'b0;
                    r1_d        = '0;
                    r2_d        = '0;
                    r3_d        = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    result_d    = '0;
                    carry_d     = 1'b0;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
                    error_d     = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            const_w_q   <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            const_w_q   <= const_w_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            enable_q    <= enable_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            error_q     <= error_d;
`endif
        end
    end

    assign req_ready              = (state_q == ST_IDLE);
    assign rsp_valid              = rsp_valid_q;
    assign rsp_result             = result_q;
    assign rsp_carry_out          = carry_q;
`ifdef DPA_ALU_DRV_TIMEOUT_EN
    assign rsp_error              = error_q;
`else
    assign rsp_error              = 1'b0;
`endif
    assign alu_reg_1              = reg1_q;
    assign alu_reg_2              = reg2_q;
    assign alu_const_w            = const_w_q;
    assign alu_const_0            = '0;
    assign alu_carry_in           = ctrl_q.carry_in;
    assign alu_reg_1_sel          = ctrl_q.reg_1_sel;
    assign alu_invert_sel         = ctrl_q.invert_sel;
    assign alu_function_array_sel = ctrl_q.function_array_sel;
    assign alu_shift_sel          = ctrl_q.shift_sel;
    assign alu_r_1                = r1_q;
    assign alu_r_2                = r2_q;
    assign alu_r_3                = r3_q;
    assign alu_enable             = enable_q;

endmodule
`default_nettype wire

// File: tb/tb_dpa_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpa_alu_driver
// Purpose  : Directed and random checks of dpa_alu_driver against a bench ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpa_alu_driver;
    import dpa_alu_drv_pkg::*;

    localparam int W = 32;
    localparam int S = 3;
    localparam int M = 2 * (S - 1) + 3;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           req_valid, req_ready;
    logic [W-1:0]   req_op_a, req_op_b, req_const_w;
    logic           req_carry_in, req_invert_sel;
    logic [1:0]     req_reg_1_sel, req_function_array_sel;
    logic [2:0]     req_shift_sel;
    logic           rsp_valid, rsp_ready, rsp_carry_out, rsp_error;
    logic [W-1:0]   rsp_result;
    logic [S*W-1:0] alu_reg_1, alu_reg_2, alu_out;
    logic [W-1:0]   alu_const_w, alu_const_0, alu_r_1, alu_r_2, alu_r_3;
    logic           alu_carry_in, alu_invert_sel, alu_enable, alu_ready;
    logic [1:0]     alu_reg_1_sel, alu_function_array_sel;
    logic [2:0]     alu_shift_sel;
    logic [S-1:0]   alu_carry_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    dpa_alu_driver #(
        .WIDTH(W), .SHARES(S), .LFSR_SEED(32'hACE1_2468), .TIMEOUT_CYCLES(64)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_const_w(req_const_w),
        .req_carry_in(req_carry_in), .req_reg_1_sel(req_reg_1_sel),
        .req_invert_sel(req_invert_sel), .req_function_array_sel(req_function_array_sel),
        .req_shift_sel(req_shift_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry_out(rsp_carry_out), .rsp_error(rsp_error),
        .alu_reg_1(alu_reg_1), .alu_reg_2(alu_reg_2),
        .alu_const_w(alu_const_w), .alu_const_0(alu_const_0),
        .alu_carry_in(alu_carry_in), .alu_reg_1_sel(alu_reg_1_sel),
        .alu_invert_sel(alu_invert_sel), .alu_function_array_sel(alu_function_array_sel),
        .alu_shift_sel(alu_shift_sel),
        .alu_r_1(alu_r_1), .alu_r_2(alu_r_2), .alu_r_3(alu_r_3),
        .alu_enable(alu_enable), .alu_out(alu_out),
        .alu_carry_out(alu_carry_out), .alu_ready(alu_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] xor_shares(input logic [S*W-1:0] v);
        logic [W-1:0] acc = '0;
        for (int i = 0; i < S; i++) acc = acc ^ v[i*W +: W];
        return acc;
    endfunction

    // Bench ALU: reg_1 (or const_0) + shifted/optionally inverted reg_2 + carry.
    function automatic logic [W:0] alu_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cin, input logic [1:0] sel1,
                                             input logic inv, input logic [2:0] sh);
        logic [W-1:0] op1, op2;
        op1 = (sel1 == REG1_SEL_CONST0) ? '0 : x;
        case (sh)
            SHIFT_SRA1: op2 = {y[W-1], y[W-1:1]};
            SHIFT_SLL1: op2 = {y[W-2:0], 1'b0};
            SHIFT_SRL1: op2 = {1'b0, y[W-1:1]};
            default:    op2 = y;
        endcase
        if (inv) op2 = ~op2;
        return {1'b0, op1} + {1'b0, op2} + {{W{1'b0}}, cin};
    endfunction

    task automatic send_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [1:0] sel1, input logic inv,
                            input logic [2:0] sh, input logic early_rdy);
        int  n;
        logic differ;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        req_valid = 1'b1; req_op_a = a; req_op_b = b; req_const_w = a ^ b;
        req_carry_in = cin; req_reg_1_sel = sel1; req_invert_sel = inv;
        req_function_array_sel = FUNC_ADD; req_shift_sel = sh;
        @(negedge clock);
        req_valid = 1'b0; req_op_a = '0; req_op_b = '0;
        alu_ready = early_rdy;
        n = 1;
        while (!alu_enable && n < 40) begin @(negedge clock); n++; end
        alu_ready = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(M + 2));
        check({tag, " reg_1 xor"}, 64'(xor_shares(alu_reg_1)), 64'(a));
        check({tag, " reg_2 xor"}, 64'(xor_shares(alu_reg_2)), 64'(b));
        differ = 1'b1;
        for (int i = 0; i < S; i++) begin
            if (alu_reg_1[i*W +: W] == a || alu_reg_2[i*W +: W] == b) differ = 1'b0;
        end
        check({tag, " shares masked"}, 64'(differ), 64'd1);
        check({tag, " r nonzero"}, 64'(alu_r_1 != '0 && alu_r_2 != '0 && alu_r_3 != '0), 64'd1);
        check({tag, " ctrl copy"}, 64'({alu_shift_sel, alu_carry_in, alu_const_w}), 64'({sh, cin, a ^ b}));
        check({tag, " busy"}, 64'(req_ready), 64'd0);
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] exp_res, input logic exp_c,
                             input int hold, input int rdy_dly);
        logic [W:0]   sum;
        logic [W-1:0] acc, m;
        logic         cacc, cm, ok;
        sum = alu_model(xor_shares(alu_reg_1), xor_shares(alu_reg_2), alu_carry_in,
                        alu_reg_1_sel, alu_invert_sel, alu_shift_sel);
        repeat (rdy_dly) @(negedge clock);
        check({tag, " enable held"}, 64'(alu_enable), 64'd1);
        acc = sum[W-1:0]; cacc = sum[W];
        for (int i = 0; i < S - 1; i++) begin
            m = $urandom; cm = 1'($urandom);
            alu_out[i*W +: W] = m; alu_carry_out[i] = cm;
            acc = acc ^ m; cacc = cacc ^ cm;
        end
        alu_out[(S-1)*W +: W] = acc; alu_carry_out[S-1] = cacc;
        alu_ready = 1'b1;
        @(negedge clock);
        alu_ready = 1'b0; alu_out = '0; alu_carry_out = '0;
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, " enable drop"}, 64'(alu_enable), 64'd0);
        check({tag, " r cleared"}, 64'({alu_r_1, alu_r_2} | 64'(alu_r_3)), 64'd0);
        check({tag, " result"}, 64'(rsp_result), 64'(exp_res));
        check({tag, " carry"}, 64'(rsp_carry_out), 64'(exp_c));
        check({tag, " error"}, 64'(rsp_error), 64'd0);
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(negedge clock);
                if (rsp_result !== exp_res || rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                    alu_enable !== 1'b0) ok = 1'b0;
            end
            check({tag, " held stable"}, 64'(ok), 64'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check({tag, " rsp done"}, 64'(rsp_valid), 64'd0);
        check({tag, " idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W:0]   g;
        logic [1:0]   rsel;
        logic         rcin, rinv, ok;
        logic [2:0]   rsh;
        int           n;
        reset_n = 1'b0; req_valid = 1'b0; req_op_a = '0; req_op_b = '0; req_const_w = '0;
        req_carry_in = 1'b0; req_reg_1_sel = '0; req_invert_sel = 1'b0;
        req_function_array_sel = '0; req_shift_sel = '0; rsp_ready = 1'b0;
        alu_out = '0; alu_carry_out = '0; alu_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst enable", 64'(alu_enable), 64'd0);
        check("rst r_1", 64'(alu_r_1), 64'd0);
        check("rst reg_1", 64'(xor_shares(alu_reg_1) | alu_reg_1[W-1:0]), 64'd0);
        check("rst result", 64'({rsp_error, rsp_carry_out, rsp_result}), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        send_req("add5m3", 32'd5, 32'hFFFF_FFFD, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_NONE, 1'b0);
        finish_op("add5m3", 32'd2, 1'b1, 0, 1);
        send_req("addm1p2", 32'hFFFF_FFFF, 32'd2, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_NONE, 1'b1);
        finish_op("addm1p2", 32'd1, 1'b1, 0, 0);
        send_req("sra", 32'd7, 32'hFFFF_FFF8, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_SRA1, 1'b0);
        finish_op("sra", 32'd3, 1'b1, 0, 2);
        send_req("const0", 32'd9, 32'd0, 1'b0, REG1_SEL_CONST0, 1'b0, SHIFT_NONE, 1'b1);
        finish_op("const0", 32'd0, 1'b0, 5, 0);
        send_req("sub", 32'd10, 32'd3, 1'b1, REG1_SEL_REG1, 1'b1, SHIFT_NONE, 1'b0);
        finish_op("sub", 32'd7, 1'b1, 0, 1);

        send_req("abort", 32'd100, 32'd23, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_NONE, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort enable", 64'(alu_enable), 64'd0);
        check("abort rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort req_ready", 64'(req_ready), 64'd1);
        check("abort masks", 64'({alu_r_1, alu_r_2}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_req("post", 32'd100, 32'd23, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_NONE, 1'b0);
        finish_op("post", 32'd123, 1'b0, 0, 0);

`ifdef DPA_ALU_DRV_TIMEOUT_EN
        send_req("tmo", 32'd1, 32'd1, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_NONE, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clock); n++; end
        check("tmo cycles", 64'(n), 64'd64);
        check("tmo error", 64'(rsp_error), 64'd1);
        check("tmo fields", 64'({rsp_carry_out, rsp_result}), 64'd0);
        check("tmo enable", 64'(alu_enable), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("tmo idle", 64'(req_ready), 64'd1);
`else
        send_req("hold", 32'd1, 32'd1, 1'b0, REG1_SEL_REG1, 1'b0, SHIFT_NONE, 1'b0);
        ok = 1'b1;
        repeat (80) begin
            @(negedge clock);
            if (alu_enable !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
        end
        check("hold wait", 64'(ok), 64'd1);
        finish_op("hold", 32'd2, 1'b0, 0, 0);
`endif

        for (int k = 0; k < 100; k++) begin
            ra = $urandom; rb = $urandom;
            rcin = 1'($urandom_range(0, 1));
            rinv = 1'($urandom_range(0, 1));
            rsh  = 3'($urandom_range(0, 3));
            rsel = ($urandom_range(0, 3) == 0) ? REG1_SEL_CONST0 : REG1_SEL_REG1;
            g = alu_model(ra, rb, rcin, rsel, rinv, rsh);
            send_req($sformatf("rnd%0d", k), ra, rb, rcin, rsel, rinv, rsh, 1'($urandom_range(0, 1)));
            finish_op($sformatf("rnd%0d", k), g[W-1:0], g[W], 0, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
